// File: rtl/counter_arbiter_if.sv
// Requester-side bus of counter_arbiter: request/direction vectors in,
// one-hot grant plus shared counter status out.
interface counter_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 2
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  dir;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] count;
  logic             step;
  logic             busy;

  modport master (output req, output dir, input gnt, input count, input step, input busy);
  modport slave  (input req, input dir, output gnt, output count, output step, output busy);
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one up/down counter among NREQ requesters, at most
// BURST steps per tenure. Define SATURATE_EN to clamp at 0/max instead of wrapping.
module counter_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 2,
  parameter int BURST = 4
) (
  input logic               clk,
  input logic               rst,
  counter_arbiter_if.slave  bus
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [LW-1:0]    last;
  logic [LW-1:0]    win;
  logic [BW-1:0]    bc;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  win_oh;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] cnt_nxt;
  logic             step;
  logic             moved;
  logic             found;
  logic             last_step;
  int unsigned      idx;

  // Search starts just after the previous winner, so the last one served has lowest priority.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[LW'(idx)]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // During GRANT, last holds the current owner, so its dir bit selects the step.
  always_comb begin
    cnt_nxt = count;
    moved   = 1'b0;
    if (bus.dir[last]) begin
`ifdef SATURATE_EN
      if (count != '1) begin
        cnt_nxt = count + 1'b1;
        moved   = 1'b1;
      end
`else
      cnt_nxt = count + 1'b1;
      moved   = 1'b1;
`endif
    end else begin
`ifdef SATURATE_EN
      if (count != '0) begin
        cnt_nxt = count - 1'b1;
        moved   = 1'b1;
      end
`else
      cnt_nxt = count - 1'b1;
      moved   = 1'b1;
`endif
    end
  end

  assign last_step = (bc == BW'(BURST - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      count <= '0;
      step  <= 1'b0;
      last  <= LW'(NREQ - 1);
      bc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          step <= 1'b0;
          if (found) begin
            gnt   <= win_oh;
            last  <= win;
            bc    <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (bus.req[last]) begin
            count <= cnt_nxt;
            step  <= moved;
            bc    <= bc + 1'b1;
            if (last_step) begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else begin
            step  <= 1'b0;
            gnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt;
  assign bus.count = count;
  assign bus.step  = step;
  assign bus.busy  = (state == GRANT);

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: directed scenarios then random traffic,
// compared against an owner/tenure reference model of the arbitration rules.
module tb_counter_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 2;
  localparam int BURST = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  // reference model: current owner (-1 = nobody), steps taken, counter, last winner
  int m_owner;
  int m_bc;
  int m_cnt;
  int m_last;
  int m_step;

  counter_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_owner = -1;
    m_bc    = 0;
    m_cnt   = 0;
    m_last  = NREQ - 1;
    m_step  = 0;
  endtask

  task automatic model_edge(input int r, input int d);
    int nv;
    if (m_owner < 0) begin
      m_step = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (m_owner < 0 && ((r >> c) & 1) == 1) begin
          m_owner = c;
          m_last  = c;
          m_bc    = 0;
        end
      end
    end else if (((r >> m_owner) & 1) == 1) begin
      nv = (((d >> m_owner) & 1) == 1) ? m_cnt + 1 : m_cnt - 1;
`ifdef SATURATE_EN
      if (nv < 0 || nv > MAXV) nv = m_cnt;
`else
      nv = (nv + MAXV + 1) % (MAXV + 1);
`endif
      m_step = (nv != m_cnt) ? 1 : 0;
      m_cnt  = nv;
      m_bc   = m_bc + 1;
      if (m_bc == BURST) m_owner = -1;
    end else begin
      m_step  = 0;
      m_owner = -1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gnt"},   32'(bus.gnt),   (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
    check({tag, ".count"}, 32'(bus.count), 32'(m_cnt));
    check({tag, ".step"},  32'(bus.step),  32'(m_step));
    check({tag, ".busy"},  32'(bus.busy),  (m_owner < 0) ? 32'd0 : 32'd1);
  endtask

  task automatic cycle(input string tag, input int r, input int d);
    bus.req = NREQ'(r);
    bus.dir = NREQ'(d);
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    int r;
    int d;
    n_assert = 0;
    n_fail   = 0;
    model_reset();

    // reset held from t=0, released at 15ns
    rst     = 1'b0;
    bus.req = '0;
    bus.dir = '0;
    #4;
    check_all("rst_t4");
    #2;
    check_all("rst_t6");
    #9;
    rst = 1'b1;
    #1;
    check_all("rst_rel");

    // single requester counting up with wrap, then re-grant after an idle cycle
    for (int i = 0; i < 6; i++) cycle("up_wrap", 1, 1);
    check("wrap_count", 32'(bus.count), 32'd0);
    check("regrant", 32'(bus.gnt), 32'd1);

    // both requesting: owner 0 counts up, then owner 1 counts down
    for (int i = 0; i < 12; i++) cycle("rr", 3, 1);

    // requester 1 alone, drops request after two steps
    cycle("drop_idle", 0, 0);
    cycle("drop_gnt", 2, 0);
    cycle("drop_s1", 2, 0);
    cycle("drop_s2", 2, 0);
    cycle("drop_rel", 0, 0);
    check("drop_nogrant", 32'(bus.gnt), 32'd0);

    // asynchronous reset in the middle of a tenure
    cycle("mid_idle", 0, 0);
    cycle("mid_gnt", 1, 1);
    cycle("mid_s1", 1, 1);
    cycle("mid_s2", 1, 1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    @(posedge clk);
    #1;
    check_all("mid_rst_hold");
    #2;
    rst = 1'b1;

`ifdef SATURATE_EN
    // blocked down-steps at zero still consume the burst
    bus.req = '0;
    for (int i = 0; i < 5; i++) cycle("sat", 2, 0);
    check("sat_count", 32'(bus.count), 32'd0);
    check("sat_drop", 32'(bus.gnt), 32'd0);
`endif

    // random traffic with sticky request patterns
    r = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 3));
      cycle("rand", r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
